// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute controller for the 16-bit ALU + CCR datapath: sequences
// operand read, condition check, ALU evaluation and register/CCR write-back.
module alu_exec_sequencer #(
  parameter logic [2:0] ALU_ADD  = 3'b000,
  parameter logic [2:0] ALU_NAND = 3'b010,
  parameter int         CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       op,
  input  logic [1:0]       cond,
  input  logic [2:0]       rs_a,
  input  logic [2:0]       rs_b,
  input  logic [2:0]       rd,
  output logic [2:0]       rf_ra1,
  output logic [2:0]       rf_ra2,
  input  logic [15:0]      rf_rd1,
  input  logic [15:0]      rf_rd2,
  output logic [15:0]      bus_a,
  output logic [15:0]      bus_b,
  output logic [2:0]       alu_control,
  input  logic [15:0]      out_alu,
  input  logic             carry,
  input  logic             zero,
  input  logic             ccr_carry,
  input  logic             ccr_zero,
  output logic             ccr_carry_we,
  output logic             ccr_zero_we,
  output logic             ccr_carry_d,
  output logic             ccr_zero_d,
  output logic             rf_we,
  output logic [2:0]       rf_wa,
  output logic [15:0]      rf_wd,
  output logic             done,
  output logic             skipped,
  output logic             illegal,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
);

  localparam logic [1:0] OP_ADD      = 2'b00;
  localparam logic [1:0] OP_NAND     = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_CARRY  = 2'b10;
  localparam logic [1:0] COND_ZERO   = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    EXEC = 2'b10,
    WB   = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [1:0]  op_p0, cond_p0;
  logic [2:0]  rs_a_p0, rs_b_p0, rd_p0;
  logic [15:0] result_p2;
  logic        carry_p2, zero_p2;
  logic        read_legal, read_go;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic instr_legal(input logic [1:0] o, input logic [1:0] c);
    instr_legal = ((o == OP_ADD) || (o == OP_NAND)) && (c != 2'b11);
  endfunction

  function automatic logic cond_true(input logic [1:0] c, input logic f_c, input logic f_z);
    cond_true = 1'b0;
    case (c)
      COND_ALWAYS: cond_true = 1'b1;
      COND_CARRY:  cond_true = f_c;
      COND_ZERO:   cond_true = f_z;
      default:     cond_true = 1'b0;
    endcase
  endfunction

  // The CCR seen here already reflects the previous WB: at least two idle/read
  // cycles always separate a WB from the next READ.
  assign read_legal = instr_legal(op_p0, cond_p0);
  assign read_go    = cond_true(cond_p0, ccr_carry, ccr_zero);

  assign rf_ra1 = rs_a_p0;
  assign rf_ra2 = rs_b_p0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    instr_ready  = 1'b0;
    alu_control  = 3'b000;
    rf_we        = 1'b0;
    rf_wa        = 3'd0;
    rf_wd        = 16'h0000;
    ccr_carry_we = 1'b0;
    ccr_zero_we  = 1'b0;
    ccr_carry_d  = 1'b0;
    ccr_zero_d   = 1'b0;
    done         = skipped | illegal;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: begin
        state_nxt = (read_legal && read_go) ? EXEC : IDLE;
      end
      EXEC: begin
        alu_control = (op_p0 == OP_NAND) ? ALU_NAND : ALU_ADD;
        state_nxt   = WB;
      end
      WB: begin
        rf_we        = 1'b1;
        rf_wa        = rd_p0;
        rf_wd        = result_p2;
        ccr_carry_we = (op_p0 == OP_ADD);
        ccr_zero_we  = 1'b1;
        ccr_carry_d  = carry_p2;
        ccr_zero_d   = zero_p2;
        done         = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: instruction fields captured at the handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_p0   <= 2'b00;
      cond_p0 <= 2'b00;
      rs_a_p0 <= 3'd0;
      rs_b_p0 <= 3'd0;
      rd_p0   <= 3'd0;
    end else if (state == IDLE && instr_valid) begin
      op_p0   <= op;
      cond_p0 <= cond;
      rs_a_p0 <= rs_a;
      rs_b_p0 <= rs_b;
      rd_p0   <= rd;
    end
  end

  // p1: operand buses; skip/illegal retire pulses land in the following IDLE cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_a      <= 16'h0000;
      bus_b      <= 16'h0000;
      skipped    <= 1'b0;
      illegal    <= 1'b0;
      skip_count <= '0;
    end else begin
      skipped <= 1'b0;
      illegal <= 1'b0;
      if (state == READ) begin
        bus_a <= rf_rd1;
        bus_b <= rf_rd2;
        if (!read_legal) begin
          illegal <= 1'b1;
        end else if (!read_go) begin
          skipped    <= 1'b1;
          skip_count <= sat_inc(skip_count);
        end
      end
    end
  end

  // p2: ALU result and flags held for the write-back cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_p2  <= 16'h0000;
      carry_p2   <= 1'b0;
      zero_p2    <= 1'b0;
      exec_count <= '0;
    end else if (state == EXEC) begin
      result_p2  <= out_alu;
      carry_p2   <= carry;
      zero_p2    <= zero;
      exec_count <= sat_inc(exec_count);
    end
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execute controller for the 16-bit ALU + CCR datapath.
- Accepts one decoded register-register instruction at a time over a valid/ready handshake.
- Per instruction: reads two operands from the register file, evaluates the carry/zero execution condition against the stored CCR, drives the ALU, then writes the result and CCR flags back.
- Sits between the decode stage and the ALU/CCR/register-file datapath.

Parameters:
- ALU_ADD, 3'b000, alu_control code driven for ADD.
- ALU_NAND, 3'b010, alu_control code driven for NAND.
- CNT_W, 8, width of the executed and skipped instruction counters.

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears every register.
- instr_valid  input  1  decode offers an instruction.
- instr_ready  output  1  high only in IDLE.
- op  input  2  00=ADD, 10=NAND, 01/11=illegal.
- cond  input  2  00=always, 10=execute only if CCR carry=1, 01=execute only if CCR zero=1, 11=illegal.
- rs_a, rs_b, rd  input  3 each  source and destination register addresses.
- rf_ra1, rf_ra2  output  3 each  register-file read addresses.
- rf_rd1, rf_rd2  input  16 each  register-file read data (combinational).
- bus_a, bus_b  output  16 each  registered ALU operands.
- alu_control  output  3  ALU operation select.
- out_alu  input  16  ALU result.
- carry, zero  input  1 each  ALU combinational flags.
- ccr_carry, ccr_zero  input  1 each  stored CCR flags.
- ccr_carry_we, ccr_zero_we  output  1 each  CCR write enables, one-cycle pulse.
- ccr_carry_d, ccr_zero_d  output  1 each  CCR write data.
- rf_we  output  1  register-file write enable, one-cycle pulse.
- rf_wa  output  3  write address.
- rf_wd  output  16  write data.
- done  output  1  one-cycle pulse when an instruction retires (executed, skipped or illegal).
- skipped  output  1  qualifies done: condition false.
- illegal  output  1  qualifies done: bad op/cond.
- exec_count, skip_count  output  CNT_W each  saturating statistics counters.

Behaviour:
- Reset values: every output 0 except instr_ready=1. State=IDLE. Latched fields, result and counters = 0. Reset mid-instruction abandons it with no write.
- States: IDLE, READ, EXEC, WB.
- IDLE
  - instr_ready=1.
  - On instr_valid=1 at an edge: latch op/cond/rs_a/rs_b/rd and go to READ. Inputs are ignored outside IDLE.
- READ
  - rf_ra1/rf_ra2 driven from the latched rs_a/rs_b.
  - bus_a<=rf_rd1 and bus_b<=rf_rd2 at the edge.
  - Illegal op or cond: next=IDLE; pulse done=1, illegal=1 in the following (IDLE) cycle; no writes.
  - Otherwise, condition false (evaluated on ccr_carry/ccr_zero this cycle): next=IDLE; pulse done=1, skipped=1; skip_count++.
  - Otherwise: next=EXEC.
- EXEC
  - alu_control=ALU_ADD or ALU_NAND (held 0 in all other states).
  - At the edge, capture out_alu, carry and zero into result registers; next=WB.
- WB (all registered outputs valid for exactly this cycle)
  - rf_we=1, rf_wa=rd, rf_wd=captured result.
  - ADD: ccr_carry_we=1, ccr_zero_we=1.
  - NAND: ccr_zero_we=1 only; ccr_carry_we=0.
  - ccr_*_d = captured flags.
  - done=1; exec_count++; next=IDLE.
- Latency (handshake accepted at edge N):
  - READ = cycle N+1, EXEC = N+2, WB/done = N+3, instr_ready high again at N+4.
  - Skip or illegal: done at N+2, instr_ready=1 in that same cycle.
- Condition check uses CCR state after the previous instruction's WB. The earliest following READ is 2 cycles after that WB, so the check always sees the updated flags.
- rf_wa=0 is a normal write; register 0 is not special-cased.
- Counters saturate at all-ones and do not wrap.
- done, skipped, illegal, rf_we and ccr_*_we are never high for more than one consecutive cycle per instruction.
- bus_a/bus_b hold their last value between instructions.

Test Plan:
- Reset, then ADD r1=0x7FFF, r2=0x0001, rd=3 -> WB at cycle N+3: rf_wd=0x8000, rf_wa=3, ccr_carry_d=0, ccr_zero_d=0, both CCR write enables=1, exec_count=1.
- ADD 0xFFFF+0x0001 -> rf_wd=0x0000, carry_d=1, zero_d=1. Then NAND 0xFFFF,0xFFFF -> rf_wd=0x0000, ccr_zero_we=1, ccr_carry_we=0.
- ccr_carry=0, cond=10 -> done at N+2 with skipped=1, no rf_we/ccr writes, skip_count=1. Repeat with ccr_carry=1 -> executes normally.
- op=01 -> done+illegal at N+2, no writes, counters unchanged. cond=11 -> same response.
- Assert reset during EXEC -> all outputs 0 and instr_ready=1 immediately (asynchronous), no rf_we afterwards. A new instruction then executes correctly.
- Hold instr_valid high for 300 back-to-back ADDs -> one accept every 4 cycles, instr_ready low during READ/EXEC/WB, exec_count saturates at 255.
